// File: rtl/bp_pkg.sv
// bp_pkg: shared width, controller states and the fall-through default for the branch-prediction table
package bp_pkg;

    localparam int ADDR_W = 15;

    typedef enum logic {SWEEP, RUN} state_t;

    function automatic logic [ADDR_W-1:0] bp_default(input logic [ADDR_W-1:0] addr);
        return addr + 1'b1;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: pc/target update queue with synchronous clear, exposing every slot for forwarding
module bp_upd_fifo import bp_pkg::*; #(
    parameter int AW    = 15,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic [AW-1:0] push_pc,
    input  logic [AW-1:0] push_tgt,
    input  logic          pop,
    output logic [AW-1:0] head_pc,
    output logic [AW-1:0] head_tgt,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] ent_pc [DEPTH],
    output logic [AW-1:0] ent_tgt [DEPTH],
    output logic [DEPTH-1:0] ent_valid,
    output logic [PW-1:0] wptr
);

    logic [PW-1:0] rptr;
    logic [PW:0]   cnt;

    assign full     = cnt == (PW+1)'(DEPTH);
    assign empty    = cnt == '0;
    assign head_pc  = ent_pc[rptr];
    assign head_tgt = ent_tgt[rptr];

    // push never targets the popped slot: push needs a free slot, pop needs a filled one
    always_ff @(posedge clk) begin
        if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            ent_valid <= '0;
        end else begin
            if (push) begin
                ent_pc[wptr]    <= push_pc;
                ent_tgt[wptr]   <= push_tgt;
                ent_valid[wptr] <= 1'b1;
                wptr            <= wptr + 1'b1;
            end
            if (pop) begin
                ent_valid[rptr] <= 1'b0;
                rptr            <= rptr + 1'b1;
            end
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

endmodule

// File: rtl/bp_ctrl.sv
// bp_ctrl: sweeps the prediction table to fall-through defaults, serialises updates and forwards queued targets
module bp_ctrl import bp_pkg::*; #(
    parameter int ADDR_W = bp_pkg::ADDR_W,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    output logic              busy,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic [ADDR_W-1:0] pred_pc,
    output logic              pred_valid,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    output logic [ADDR_W-1:0] bp_raddr0,
    input  logic [ADDR_W-1:0] bp_rdata0,
    output logic              bp_wen,
    output logic [ADDR_W-1:0] bp_waddr,
    output logic [ADDR_W-1:0] bp_wdata
);

    localparam int PW = $clog2(QDEPTH);

    state_t            state;
    logic [ADDR_W-1:0] ptr, head_pc, head_tgt, fwd_tgt;
    logic [ADDR_W-1:0] ent_pc [QDEPTH];
    logic [ADDR_W-1:0] ent_tgt [QDEPTH];
    logic [QDEPTH-1:0] ent_valid;
    logic [PW-1:0]     wptr, slot;
    logic              clr, push, pop, full, empty, hit;

    assign clr        = reset || flush;
    assign upd_ready  = !full && !clr;
    assign push       = upd_valid && upd_ready;
    assign pop        = state == RUN && !empty && !clr;
    assign busy       = reset || state == SWEEP;
    assign pred_valid = !busy;
    assign bp_raddr0  = fetch_pc;
    assign bp_wen     = !reset && (state == SWEEP || pop);
    assign bp_waddr   = state == SWEEP ? ptr : head_pc;
    assign bp_wdata   = state == SWEEP ? bp_default(ptr) : head_tgt;
    assign pred_pc    = busy ? bp_default(fetch_pc) : hit ? fwd_tgt : bp_rdata0;

    bp_upd_fifo #(.AW(ADDR_W), .DEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .push_pc   (upd_pc),
        .push_tgt  (upd_target),
        .pop       (pop),
        .head_pc   (head_pc),
        .head_tgt  (head_tgt),
        .full      (full),
        .empty     (empty),
        .ent_pc    (ent_pc),
        .ent_tgt   (ent_tgt),
        .ent_valid (ent_valid),
        .wptr      (wptr)
    );

    // walk from oldest to newest so the youngest matching entry wins
    always_comb begin
        hit     = 1'b0;
        fwd_tgt = '0;
        slot    = '0;
        for (int a = QDEPTH - 1; a >= 0; a--) begin
            slot = wptr - PW'(a) - 1'b1;
            if (ent_valid[slot] && ent_pc[slot] == fetch_pc) begin
                hit     = 1'b1;
                fwd_tgt = ent_tgt[slot];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= SWEEP;
            ptr   <= '0;
        end else if (state == SWEEP) begin
            ptr <= ptr + 1'b1;
            if (&ptr) state <= RUN;
        end
    end

endmodule

// File: tb/tb_bp_ctrl.sv
// tb_bp_ctrl: directed and random stimulus for bp_ctrl against a last-accepted-target prediction model
module tb_bp_ctrl;

    localparam int AW = 15;
    localparam int QD = 4;
    localparam logic [31:0] MASK = 32'h7fff;

    logic          clk = 1'b0;
    logic          reset, flush, busy, pred_valid, upd_valid, upd_ready, bp_wen;
    logic [AW-1:0] fetch_pc, pred_pc, upd_pc, upd_target, bp_raddr0, bp_rdata0, bp_waddr, bp_wdata;
    logic [AW-1:0] mem [1<<AW];

    typedef struct {int pc; int tgt;} upd_t;
    upd_t pend[$];
    int   last_tgt[int];
    bit   in_sweep = 1'b1;
    int   sw_addr = 0;
    int   checks = 0;
    int   errors = 0;
    bit   acc;

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (bp_wen) mem[bp_waddr] <= bp_wdata;
    assign bp_rdata0 = mem[bp_raddr0];

    bp_ctrl #(.ADDR_W(AW), .QDEPTH(QD)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .busy       (busy),
        .fetch_pc   (fetch_pc),
        .pred_pc    (pred_pc),
        .pred_valid (pred_valid),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .bp_raddr0  (bp_raddr0),
        .bp_rdata0  (bp_rdata0),
        .bp_wen     (bp_wen),
        .bp_waddr   (bp_waddr),
        .bp_wdata   (bp_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock cycle: check outputs against the model, then advance the model across the edge
    task automatic step();
        bit rdy;
        int f;
        #1;
        f   = int'(fetch_pc);
        rdy = !reset && !flush && pend.size() < QD;
        chk("upd_ready", upd_ready, rdy);
        chk("bp_raddr0", bp_raddr0, f);
        if (reset) begin
            chk("rst_busy", busy, 1);
            chk("rst_wen", bp_wen, 0);
            chk("rst_pred_valid", pred_valid, 0);
        end else if (in_sweep) begin
            chk("sw_busy", busy, 1);
            chk("sw_pred_valid", pred_valid, 0);
            chk("sw_pred_pc", pred_pc, (f + 1) & MASK);
            chk("sw_wen", bp_wen, 1);
            chk("sw_waddr", bp_waddr, sw_addr);
            chk("sw_wdata", bp_wdata, (sw_addr + 1) & MASK);
        end else begin
            chk("run_busy", busy, 0);
            chk("run_pred_valid", pred_valid, 1);
            chk("run_pred_pc", pred_pc, last_tgt.exists(f) ? last_tgt[f] : (f + 1) & MASK);
            chk("run_wen", bp_wen, !flush && pend.size() > 0);
            if (!flush && pend.size() > 0) begin
                chk("run_waddr", bp_waddr, pend[0].pc);
                chk("run_wdata", bp_wdata, pend[0].tgt);
            end
        end
        acc = upd_valid && rdy;
        if (reset || flush) begin
            in_sweep = 1'b1;
            sw_addr  = 0;
            pend.delete();
            last_tgt.delete();
        end else begin
            if (!in_sweep && pend.size() > 0) void'(pend.pop_front());
            if (acc) begin
                pend.push_back('{int'(upd_pc), int'(upd_target)});
                last_tgt[int'(upd_pc)] = int'(upd_target);
            end
            if (in_sweep) begin
                if (sw_addr == int'(MASK)) in_sweep = 1'b0;
                else sw_addr++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int k;
        reset = 1'b1; flush = 1'b0; upd_valid = 1'b0;
        upd_pc = '0; upd_target = '0; fetch_pc = '0;
        repeat (2) step();
        reset = 1'b0;
        while (in_sweep) begin
            fetch_pc = AW'($urandom);
            step();
        end
        fetch_pc = 15'h0123;
        step();
        upd_valid = 1'b1; upd_pc = 15'h0100; upd_target = 15'h0200; fetch_pc = 15'h0100;
        step();
        upd_valid = 1'b0;
        step();
        step();
        upd_valid = 1'b1; upd_pc = 15'h0010; upd_target = 15'h0020; fetch_pc = 15'h0010;
        step();
        upd_target = 15'h0030;
        step();
        upd_valid = 1'b0;
        step();
        step();
        chk("table_dup", mem[15'h0010], 32'h30);
        for (int i = 0; i < 400; i++) begin
            upd_valid  = 1'($urandom_range(0, 1));
            upd_pc     = AW'($urandom_range(0, 7) * 16);
            upd_target = AW'($urandom);
            fetch_pc   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7) * 16);
            step();
        end
        upd_valid = 1'b1; upd_pc = 15'h0051; upd_target = 15'h0aaa; fetch_pc = 15'h0051;
        step();
        flush = 1'b1; upd_pc = 15'h0061; upd_target = 15'h0bbb;
        step();
        flush = 1'b0; upd_valid = 1'b0;
        step();
        chk("flush_discard", mem[15'h0051], 32'h52);
        for (int i = 0; i < 3; i++) begin
            upd_valid = 1'b1; upd_pc = AW'(16'h0070 + i); upd_target = AW'(16'h0700 + i);
            step();
        end
        upd_valid = 1'b0;
        while (sw_addr != 32'h4000) begin
            fetch_pc = AW'($urandom);
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        k = 0;
        while (in_sweep || pend.size() > 0 || k < 5) begin
            upd_valid = k < 5;
            upd_pc = AW'(16'h0200 + k); upd_target = AW'(16'h0300 + k);
            fetch_pc = AW'(16'h0200 + $urandom_range(0, 5));
            step();
            if (acc) k++;
        end
        upd_valid = 1'b0;
        chk("table_fifth", mem[15'h0204], 32'h304);
        upd_valid = 1'b1; upd_pc = 15'h0400; upd_target = 15'h0555;
        step();
        upd_valid = 1'b0; reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        chk("reset_discard", mem[15'h0400], 32'h401);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
